// File: rtl/early_merge_arb_pkg.sv
// rtl/early_merge_arb_pkg.sv - shared timestamp widths, flit type and due-check helper
package early_merge_arb_pkg;

  localparam int TS_W      = 3;
  localparam int TS_WINDOW = 4;
  localparam int FLIT_DW   = 32;

  typedef struct packed {
    logic [TS_W-1:0]    ts;
    logic [FLIT_DW-1:0] data;
  } flit_t;

  // A flit is due once cur_ts has caught up with it, i.e. it lies at most
  // TS_WINDOW-1 steps behind cur_ts on the wrap-around clock.
  function automatic logic ts_due(input logic [TS_W-1:0] cur, input logic [TS_W-1:0] t);
    logic [TS_W-1:0] d;
    d = cur - t;
    return d < TS_W'(TS_WINDOW);
  endfunction

endpackage

// File: rtl/early_merge_arb_ts_skid2.sv
// rtl/early_merge_arb_ts_skid2.sv - 2-entry {ts, data} output buffer with registered head
module ts_skid2
  import early_merge_arb_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            push,
  input  logic [TS_W-1:0] push_ts,
  input  logic [DW-1:0]   push_data,
  input  logic            pop,
  output logic [1:0]      cnt,
  output logic [TS_W-1:0] head_ts,
  output logic [DW-1:0]   head_data
);

  logic [TS_W-1:0] tail_ts;
  logic [DW-1:0]   tail_data;
  logic            do_pop;

  assign do_pop = pop & (cnt != 2'd0);

  // Head/tail shuffle; push with pop at count 1 writes the new flit straight
  // into the head, at count 2 the tail moves up and the new flit takes its place.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt       <= 2'd0;
      head_ts   <= '0;
      head_data <= '0;
      tail_ts   <= '0;
      tail_data <= '0;
    end else begin
      case (cnt)
        2'd0: begin
          if (push) begin
            head_ts   <= push_ts;
            head_data <= push_data;
            cnt       <= 2'd1;
          end
        end
        2'd1: begin
          if (push && do_pop) begin
            head_ts   <= push_ts;
            head_data <= push_data;
          end else if (push) begin
            tail_ts   <= push_ts;
            tail_data <= push_data;
            cnt       <= 2'd2;
          end else if (do_pop) begin
            cnt <= 2'd0;
          end
        end
        default: begin
          if (do_pop) begin
            head_ts   <= tail_ts;
            head_data <= tail_data;
            if (push) begin
              tail_ts   <= push_ts;
              tail_data <= push_data;
            end else begin
              cnt <= 2'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/select_early_3b.sv
// rtl/select_early_3b.sv - picks the earliest valid lane by 3-bit wrap-around timestamp
module select_early_3b #(
  parameter int N  = 2,
  parameter int SW = $clog2(N)
) (
  input  logic [3*N-1:0] ts,
  input  logic [N-1:0]   valid,
  output logic [SW-1:0]  sel,
  output logic           sel_valid
);

  logic [2:0] best_ts;
  logic [2:0] cand;

  // a strictly precedes b when b is 1..3 steps ahead of a on the wrap-around clock
  function automatic logic earlier(input logic [2:0] a, input logic [2:0] b);
    logic [2:0] d;
    d = b - a;
    return (d != 3'd0) && (d < 3'd4);
  endfunction

  // Fold over lanes in index order; a later lane replaces the current best
  // only when strictly earlier, so ties resolve to the lower index.
  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    best_ts   = '0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = ts[3*i +: 3];
      if (valid[i] && (!sel_valid || earlier(cand, best_ts))) begin
        sel       = SW'(i);
        sel_valid = 1'b1;
        best_ts   = cand;
      end
    end
  end

endmodule

// File: rtl/early_merge_arb.sv
// rtl/early_merge_arb.sv - time-ordered N-to-1 flit merger with due check and 2-entry output buffer
module early_merge_arb
  import early_merge_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int DW = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [TS_W-1:0]  cur_ts,
  input  logic [N*DW-1:0]  in_data,
  input  logic [TS_W*N-1:0] in_ts,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  output logic [DW-1:0]    out_data,
  output logic [TS_W-1:0]  out_ts,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      fwd_count
);

  localparam int SW = $clog2(N);

  logic [SW-1:0]     lo;
  logic [TS_W*N-1:0] masked_ts;
  logic [SW-1:0]     sel;
  logic              sel_valid;
  logic [TS_W-1:0]   t_sel;
  logic              due;
  logic              pop;
  logic              acc;
  logic [1:0]        cnt;

  // Lowest valid lane; its timestamp stands in for every invalid lane.
  always_comb begin
    lo = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_valid[i]) lo = SW'(i);
    end
  end

  // Invalid lanes mirror lane lo so every subtree minimum is over valid lanes only.
  always_comb begin
    masked_ts = '0;
    for (int i = 0; i < N; i++) begin
      masked_ts[TS_W*i +: TS_W] = in_valid[i] ? in_ts[TS_W*i +: TS_W]
                                              : in_ts[TS_W*int'(lo) +: TS_W];
    end
  end

  select_early_3b #(.N(N), .SW(SW)) u_sel (
    .ts        (masked_ts),
    .valid     (in_valid),
    .sel       (sel),
    .sel_valid (sel_valid)
  );

  assign t_sel     = in_ts[TS_W*int'(sel) +: TS_W];
  assign due       = ts_due(cur_ts, t_sel);
  assign out_valid = (cnt != 2'd0);
  assign pop       = out_valid & out_ready;
  assign acc       = ~reset & sel_valid & due & ((cnt < 2'd2) | pop);
  assign in_ready  = acc ? (N'(1) << sel) : '0;

  ts_skid2 #(.DW(DW)) u_buf (
    .clock     (clock),
    .reset     (reset),
    .push      (acc),
    .push_ts   (t_sel),
    .push_data (in_data[DW*int'(sel) +: DW]),
    .pop       (pop),
    .cnt       (cnt),
    .head_ts   (out_ts),
    .head_data (out_data)
  );

  // Saturating count of flits taken from the input lanes.
  always_ff @(posedge clock) begin
    if (reset) begin
      fwd_count <= 16'd0;
    end else if (acc && (fwd_count != 16'hFFFF)) begin
      fwd_count <= fwd_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_early_merge_arb.sv
// tb/tb_early_merge_arb.sv - self-checking bench for early_merge_arb at N=2 and N=8
module tb_early_merge_arb;
  import early_merge_arb_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  cur_ts;
  logic        out_ready;

  logic [63:0]  in_data2;
  logic [5:0]   in_ts2;
  logic [1:0]   in_valid2;
  logic [1:0]   in_ready2;
  logic [31:0]  out_data2;
  logic [2:0]   out_ts2;
  logic         out_valid2;
  logic [15:0]  fwd2;

  logic [255:0] in_data8;
  logic [23:0]  in_ts8;
  logic [7:0]   in_valid8;
  logic [7:0]   in_ready8;
  logic [31:0]  out_data8;
  logic [2:0]   out_ts8;
  logic         out_valid8;
  logic [15:0]  fwd8;

  int errors = 0;
  int checks = 0;

  logic        lv [8];
  logic [2:0]  lt [8];
  logic [31:0] ld [8];

  typedef struct {
    logic [7:0]  valid;
    logic [23:0] ts;
    logic [2:0]  cur;
    logic [7:0]  exp_ready;
  } vec_t;

  vec_t vecs [13];

  always #5 clock = ~clock;

  early_merge_arb #(.N(2), .DW(32)) dut2 (
    .clock     (clock),
    .reset     (reset),
    .cur_ts    (cur_ts),
    .in_data   (in_data2),
    .in_ts     (in_ts2),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .out_data  (out_data2),
    .out_ts    (out_ts2),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .fwd_count (fwd2)
  );

  early_merge_arb #(.N(8), .DW(32)) dut8 (
    .clock     (clock),
    .reset     (reset),
    .cur_ts    (cur_ts),
    .in_data   (in_data8),
    .in_ts     (in_ts8),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .out_data  (out_data8),
    .out_ts    (out_ts8),
    .out_valid (out_valid8),
    .out_ready (out_ready),
    .fwd_count (fwd8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic drive8();
    for (int i = 0; i < 8; i++) begin
      in_valid8[i]         = lv[i];
      in_ts8[3*i +: 3]     = lt[i];
      in_data8[32*i +: 32] = ld[i];
    end
  endtask

  task automatic clear_lanes();
    for (int i = 0; i < 8; i++) begin
      lv[i] = 1'b0;
      lt[i] = 3'd0;
      ld[i] = 32'd0;
    end
    drive8();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [23:0] pts(input int a0, input int a1, input int a2, input int a3,
                                      input int a4, input int a5, input int a6, input int a7);
    return {3'(a7), 3'(a6), 3'(a5), 3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  initial begin
    int          nacc;
    int          model_fwd;
    flit_t       q [$];
    flit_t       f;
    logic        found;
    logic        ok;
    int          idx;
    logic        m_acc;
    logic        m_pop;
    logic        blocker;
    logic [7:0]  exp_rdy;

    vecs[0]  = '{8'h28, pts(0,0,0,7,0,1,0,0), 3'd7, 8'h08};
    vecs[1]  = '{8'h28, pts(0,0,0,7,0,1,0,0), 3'd1, 8'h08};
    vecs[2]  = '{8'h20, pts(0,0,0,7,0,1,0,0), 3'd7, 8'h00};
    vecs[3]  = '{8'h20, pts(0,0,0,7,0,1,0,0), 3'd1, 8'h20};
    vecs[4]  = '{8'h20, pts(0,0,0,7,0,1,0,0), 3'd4, 8'h20};
    vecs[5]  = '{8'h20, pts(0,0,0,7,0,1,0,0), 3'd5, 8'h00};
    vecs[6]  = '{8'h54, pts(0,0,4,0,4,0,4,0), 3'd4, 8'h04};
    vecs[7]  = '{8'hFF, pts(3,1,2,1,3,2,3,2), 3'd1, 8'h02};
    vecs[8]  = '{8'hFF, pts(3,1,2,1,3,2,3,2), 3'd0, 8'h00};
    vecs[9]  = '{8'h81, pts(6,0,0,0,0,0,0,1), 3'd6, 8'h01};
    vecs[10] = '{8'h42, pts(0,0,0,0,0,0,5,0), 3'd0, 8'h40};
    vecs[11] = '{8'h00, pts(1,2,3,4,5,6,7,0), 3'd3, 8'h00};
    vecs[12] = '{8'h02, pts(2,2,0,0,0,0,0,0), 3'd2, 8'h02};

    reset     = 1'b1;
    cur_ts    = 3'd1;
    out_ready = 1'b1;
    in_valid2 = 2'b11;
    in_ts2    = {3'd1, 3'd1};
    in_data2  = {32'hBBBB_0001, 32'hAAAA_0001};
    clear_lanes();

    // reset held two cycles with both N=2 lanes valid and due
    tick();
    #1;
    chk("rst_in_ready_c1", in_ready2, 2'b00);
    chk("rst_out_valid", out_valid2, 1'b0);
    chk("rst_fwd_count", fwd2, 16'd0);
    chk("rst_out_data", out_data2, 32'd0);
    chk("rst_out_ts", out_ts2, 3'd0);
    tick();
    #1;
    chk("rst_in_ready_c2", in_ready2, 2'b00);
    chk("rst8_out_valid", out_valid8, 1'b0);

    // basic pick: earlier lane 0 first, then lane 1 once it is due
    reset  = 1'b0;
    in_ts2 = {3'b010, 3'b001};
    #1;
    chk("basic_first_accept", in_ready2, 2'b01);
    tick();
    in_valid2 = 2'b10;
    cur_ts    = 3'b010;
    #1;
    chk("basic_out_valid", out_valid2, 1'b1);
    chk("basic_out_ts", out_ts2, 3'b001);
    chk("basic_out_data", out_data2, 32'hAAAA_0001);
    chk("basic_lane1", in_ready2, 2'b10);
    tick();
    in_valid2 = 2'b00;
    #1;
    chk("basic_out_ts2", out_ts2, 3'b010);
    chk("basic_out_data2", out_data2, 32'hBBBB_0001);
    chk("basic_fwd", fwd2, 16'd2);

    // table of single-cycle selection vectors on N=8
    for (int v = 0; v < 13; v++) begin
      pulse_reset();
      for (int i = 0; i < 8; i++) begin
        lv[i] = vecs[v].valid[i];
        lt[i] = vecs[v].ts[3*i +: 3];
        ld[i] = 32'hD000_0000 | 32'(v * 256 + i);
      end
      cur_ts = vecs[v].cur;
      drive8();
      #1;
      chk($sformatf("vec%0d_in_ready", v), in_ready8, vecs[v].exp_ready);
      tick();
      for (int i = 0; i < 8; i++) lv[i] = 1'b0;
      drive8();
      #1;
      chk($sformatf("vec%0d_out_valid", v), out_valid8, (vecs[v].exp_ready != 8'h00));
      for (int i = 0; i < 8; i++) begin
        if (vecs[v].exp_ready[i]) begin
          chk($sformatf("vec%0d_out_ts", v), out_ts8, lt[i]);
          chk($sformatf("vec%0d_out_data", v), out_data8, ld[i]);
        end
      end
    end

    // wrap-around: lane 3 (ts 7) first, lane 5 (ts 1) withheld until cur_ts=1
    pulse_reset();
    clear_lanes();
    lv[3] = 1'b1; lt[3] = 3'd7; ld[3] = 32'h3333_3333;
    lv[5] = 1'b1; lt[5] = 3'd1; ld[5] = 32'h5555_5555;
    cur_ts = 3'd7;
    drive8();
    #1;
    chk("wrap_lane3", in_ready8, 8'h08);
    tick();
    lv[3] = 1'b0;
    drive8();
    #1;
    chk("wrap_hold_c7", in_ready8, 8'h00);
    chk("wrap_out_ts7", out_ts8, 3'd7);
    tick();
    cur_ts = 3'd0;
    #1;
    chk("wrap_hold_c0", in_ready8, 8'h00);
    tick();
    cur_ts = 3'd1;
    #1;
    chk("wrap_lane5", in_ready8, 8'h20);
    tick();
    lv[5] = 1'b0;
    drive8();
    #1;
    chk("wrap_out_ts1", out_ts8, 3'd1);
    chk("wrap_out_data", out_data8, 32'h5555_5555);

    // tie and mask: lanes 2,4,6 at ts 4 drain in index order, invalid lane 0 never acked
    pulse_reset();
    clear_lanes();
    for (int k = 2; k <= 6; k += 2) begin
      lv[k] = 1'b1; lt[k] = 3'd4; ld[k] = 32'h7700_0000 | 32'(k);
    end
    cur_ts = 3'd4;
    drive8();
    for (int k = 2; k <= 6; k += 2) begin
      #1;
      chk($sformatf("tie_ack_lane%0d", k), in_ready8, 8'(1 << k));
      tick();
      lv[k] = 1'b0;
      drive8();
    end
    #1;
    chk("tie_drained", in_ready8, 8'h00);
    chk("tie_last_data", out_data8, 32'h7700_0006);
    chk("tie_fwd", fwd8, 16'd3);

    // back-pressure: two accepts then stall; one out_ready cycle pops and pushes
    pulse_reset();
    clear_lanes();
    out_ready = 1'b0;
    cur_ts    = 3'd3;
    lv[0] = 1'b1; lt[0] = 3'd3; ld[0] = 32'hB000_0001;
    drive8();
    nacc = 0;
    for (int k = 0; k < 5; k++) begin
      logic acked;
      #1;
      acked = in_ready8[0];
      if (acked) nacc++;
      tick();
      if (acked) ld[0] = ld[0] + 32'd1;
      drive8();
    end
    #1;
    chk("bp_accept_count", 64'(nacc), 64'd2);
    chk("bp_stalled", in_ready8, 8'h00);
    chk("bp_head", out_data8, 32'hB000_0001);
    out_ready = 1'b1;
    #1;
    chk("bp_pop_push", in_ready8, 8'h01);
    tick();
    ld[0]     = ld[0] + 32'd1;
    out_ready = 1'b0;
    drive8();
    #1;
    chk("bp_still_full", in_ready8, 8'h00);
    chk("bp_out_valid", out_valid8, 1'b1);
    chk("bp_new_head", out_data8, 32'hB000_0002);

    // mid-flight reset with a full buffer
    reset = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready8, 8'h00);
    tick();
    #1;
    chk("midrst_out_valid", out_valid8, 1'b0);
    chk("midrst_out_data", out_data8, 32'd0);
    chk("midrst_fwd", fwd8, 16'd0);
    reset = 1'b0;
    clear_lanes();

    // randomized traffic against a window-order reference model
    pulse_reset();
    clear_lanes();
    q.delete();
    model_fwd = 0;
    cur_ts    = 3'd0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      blocker = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (lv[i] && (lt[i] == 3'(cur_ts - 3'd2))) blocker = 1'b1;
      end
      if (!blocker && ($urandom_range(0, 1) == 0)) cur_ts = cur_ts + 3'd1;
      for (int i = 0; i < 8; i++) begin
        if (!lv[i] && ($urandom_range(0, 2) == 0)) begin
          lv[i] = 1'b1;
          lt[i] = 3'(cur_ts + 3'($urandom_range(0, 3)) - 3'd2);
          ld[i] = $urandom;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      drive8();
      #1;

      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < 8; i++) begin
        if (lv[i] && !found) begin
          ok = 1'b1;
          for (int j = 0; j < 8; j++) begin
            if (lv[j] && (3'(lt[j] - lt[i]) >= 3'd4)) ok = 1'b0;
          end
          if (ok) begin
            found = 1'b1;
            idx   = i;
          end
        end
      end
      m_pop   = (q.size() > 0) && out_ready;
      m_acc   = found && (3'(cur_ts - lt[idx]) <= 3'd3) && ((q.size() < 2) || m_pop);
      exp_rdy = m_acc ? 8'(1 << idx) : 8'h00;

      chk("rand_in_ready", in_ready8, exp_rdy);
      chk("rand_out_valid", out_valid8, (q.size() > 0));
      if (q.size() > 0) begin
        chk("rand_out_ts", out_ts8, q[0].ts);
        chk("rand_out_data", out_data8, q[0].data);
      end

      if (m_pop) void'(q.pop_front());
      if (m_acc) begin
        f.ts   = lt[idx];
        f.data = ld[idx];
        q.push_back(f);
        model_fwd++;
      end
      tick();
      if (m_acc) lv[idx] = 1'b0;
    end
    #1;
    chk("rand_fwd_count", fwd8, 16'(model_fwd));
    clear_lanes();

    // saturation on N=2: one accept per cycle with out_ready high
    out_ready = 1'b1;
    cur_ts    = 3'd5;
    in_valid2 = 2'b01;
    in_ts2    = {3'd5, 3'd5};
    pulse_reset();
    repeat (65534) @(posedge clock);
    #2;
    chk("sat_fffe", fwd2, 16'hFFFE);
    repeat (6) @(posedge clock);
    #2;
    chk("sat_ffff", fwd2, 16'hFFFF);
    in_valid2 = 2'b00;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
